// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer, instruction memory and the ALU.
interface instr_sequencer_if;
    // Instruction fetch port
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    // ALU control and operands
    logic [5:0]  alu_instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_reg8;
    logic [15:0] alu_value;
    logic        alu_highlow;
    logic        alu_f1;
    logic        alu_f2;
    logic        alu_strobe;
    // ALU results
    logic [31:0] alu_c;
    logic        alu_f3;
    logic        alu_addrch;
    logic [31:0] alu_naddr;
    // Status
    logic [31:0] pc;
    logic        halted;
    logic        illegal;

    // Sequencer side
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output alu_instr, alu_a, alu_b, alu_reg8, alu_value, alu_highlow,
        output alu_f1, alu_f2, alu_strobe,
        input  alu_c, alu_f3, alu_addrch, alu_naddr,
        output pc, halted, illegal
    );

    // Memory / ALU / observer side
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  alu_instr, alu_a, alu_b, alu_reg8, alu_value, alu_highlow,
        input  alu_f1, alu_f2, alu_strobe,
        output alu_c, alu_f3, alu_addrch, alu_naddr,
        input  pc, halted, illegal
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch, decode, strobe the ALU, write back, advance PC.
module instr_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NREGS    = 16
) (
    input  logic               clock,
    input  logic               reset,
    instr_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] regs [NREGS];
    logic        f1;
    logic        f2;

    logic [5:0]  alu_instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_reg8;
    logic [15:0] alu_value;
    logic        alu_highlow;

    logic [31:0] res_c;
    logic [31:0] res_naddr;
    logic        res_f3;
    logic        res_addrch;

    logic        imem_req;
    logic        alu_strobe;
    logic        halted;
    logic        illegal;

    // Instruction fields
    logic [5:0]  op;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        hl;
    logic [15:0] imm;
    logic        op_legal;
    logic        op_halt;

    assign op       = ir[31:26];
    assign rd       = ir[25:22];
    assign ra       = ir[21:18];
    assign hl       = ir[17];
    assign imm      = ir[15:0];
    assign rb       = ir[3:0];
    assign op_legal = (op < 6'd16);
    assign op_halt  = (op == 6'd63);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Next-state and handshake/strobe outputs
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        alu_strobe = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        unique case (state)
            FETCH: begin
                // Request is masked while reset is held so nothing is issued early
                imem_req = !reset;
                if (bus.imem_ack) state_next = DECODE;
            end
            DECODE: begin
                if (op_halt)       state_next = HALT;
                else if (op_legal) state_next = EXEC;
                else begin
                    illegal    = 1'b1;
                    state_next = WB;
                end
            end
            EXEC: begin
                alu_strobe = 1'b1;
                state_next = WB;
            end
            WB:      state_next = FETCH;
            HALT:    halted = 1'b1;
            default: state_next = FETCH;
        endcase
    end

    // Instruction latch, operand latch and ALU result capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir          <= '0;
            alu_instr   <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_reg8    <= '0;
            alu_value   <= '0;
            alu_highlow <= 1'b0;
            res_c       <= '0;
            res_naddr   <= '0;
            res_f3      <= 1'b0;
            res_addrch  <= 1'b0;
        end else begin
            if (state == FETCH && bus.imem_ack) ir <= bus.imem_data;
            if (state == DECODE && op_legal) begin
                alu_instr   <= op;
                alu_a       <= (ra == 4'd0) ? '0 : regs[ra];
                alu_b       <= (rb == 4'd0) ? '0 : regs[rb];
                alu_reg8    <= regs[8];
                alu_value   <= imm;
                alu_highlow <= hl;
            end
            if (state == EXEC) begin
                res_c      <= bus.alu_c;
                res_naddr  <= bus.alu_naddr;
                res_f3     <= bus.alu_f3;
                res_addrch <= bus.alu_addrch;
            end
        end
    end

    // Write-back: register file, flags and PC
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
            f1 <= 1'b0;
            f2 <= 1'b0;
            pc <= RESET_PC;
        end else if (state == WB) begin
            if (op < 6'd8 && rd != 4'd0) regs[rd] <= res_c;
            if (op >= 6'd8 && op < 6'd14) begin
                f2 <= f1;
                f1 <= res_f3;
            end
            // Illegal ops never ran EXEC, so captured branch info is ignored for them
            if (op_legal && res_addrch) pc <= res_naddr;
            else                        pc <= pc + 32'd1;
        end
    end

    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = pc;
    assign bus.alu_instr   = alu_instr;
    assign bus.alu_a       = alu_a;
    assign bus.alu_b       = alu_b;
    assign bus.alu_reg8    = alu_reg8;
    assign bus.alu_value   = alu_value;
    assign bus.alu_highlow = alu_highlow;
    assign bus.alu_f1      = f1;
    assign bus.alu_f2      = f2;
    assign bus.alu_strobe  = alu_strobe;
    assign bus.pc          = pc;
    assign bus.halted      = halted;
    assign bus.illegal     = illegal;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a small memory responder and ALU model.
module tb_instr_sequencer;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   ack_delay;
    int   wait_cnt;
    logic [31:0] mem [128];

    instr_sequencer_if bus();

    instr_sequencer #(.RESET_PC(32'h0000_0000), .NREGS(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Instruction memory responder: acks after ack_delay waiting cycles
    initial begin
        bus.imem_ack  = 1'b0;
        bus.imem_data = '0;
        wait_cnt      = 0;
        forever begin
            @(negedge clock);
            bus.imem_ack = 1'b0;
            if (bus.imem_req && !reset) begin
                if (wait_cnt == ack_delay) begin
                    bus.imem_ack  = 1'b1;
                    bus.imem_data = mem[bus.imem_addr[6:0]];
                    wait_cnt      = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ALU model; outputs gated by strobe
    always_comb begin
        bus.alu_c      = '0;
        bus.alu_f3     = 1'b0;
        bus.alu_addrch = 1'b0;
        bus.alu_naddr  = '0;
        if (bus.alu_strobe) begin
            case (bus.alu_instr)
                6'd0: bus.alu_c = bus.alu_a + bus.alu_b;
                6'd5: bus.alu_c = bus.alu_highlow ? {bus.alu_value, 16'h0} : {16'h0, bus.alu_value};
                6'd8: bus.alu_f3 = (bus.alu_a == bus.alu_b);
                6'd9: bus.alu_f3 = (bus.alu_a < bus.alu_b);
                6'd14: begin
                    bus.alu_addrch = 1'b1;
                    bus.alu_naddr  = bus.alu_reg8;
                end
                default: ;
            endcase
        end
    end

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] ra, input logic hl,
                                        input logic [15:0] imm);
        return {op, rd, ra, hl, 1'b0, imm};
    endfunction

    task automatic load_prog(input logic [31:0] p0, input logic [31:0] p1,
                             input logic [31:0] p2, input logic [31:0] p3);
        for (int i = 0; i < 128; i++) mem[i] = enc(6'd63, 4'd0, 4'd0, 1'b0, 16'h0);
        mem[0] = p0;
        mem[1] = p1;
        mem[2] = p2;
        mem[3] = p3;
    endtask

    // Reset is released 2 time units after a rising edge
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        load_prog(32'h0, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;
        #3;
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b want=0", bus.imem_req); end
        checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h want=0", bus.pc); end
        checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", bus.imem_addr); end
        checks++; if (bus.alu_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%0b want=0", bus.alu_strobe); end
        checks++; if ({bus.halted, bus.illegal, bus.alu_f1, bus.alu_f2} !== 4'b0) begin failures++; $display("FAIL reset_status got=%b want=0000", {bus.halted, bus.illegal, bus.alu_f1, bus.alu_f2}); end
        checks++; if (bus.alu_a !== 32'h0 || bus.alu_instr !== 6'h0) begin failures++; $display("FAIL reset_alu got a=%h instr=%h want 0", bus.alu_a, bus.alu_instr); end
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic test_load_add();
        ack_delay = 0;
        load_prog(enc(6'd5, 4'd1, 4'd0, 1'b0, 16'h1234),
                  enc(6'd0, 4'd2, 4'd1, 1'b0, 16'h0001),
                  enc(6'd0, 4'd3, 4'd2, 1'b0, 16'h0000),
                  enc(6'd63, 4'd0, 4'd0, 1'b0, 16'h0));
        do_reset();
        cyc(1);
        checks++; if (bus.alu_strobe !== 1'b0) begin failures++; $display("FAIL ld_decode_strobe got=%0b want=0", bus.alu_strobe); end
        cyc(1);
        checks++; if (bus.alu_strobe !== 1'b1 || bus.alu_instr !== 6'd5 || bus.alu_value !== 16'h1234)
            begin failures++; $display("FAIL ld_exec got strobe=%0b instr=%0d value=%h want 1/5/1234", bus.alu_strobe, bus.alu_instr, bus.alu_value); end
        cyc(4);
        checks++; if (bus.alu_a !== 32'h1234 || bus.alu_b !== 32'h1234)
            begin failures++; $display("FAIL add_operands got a=%h b=%h want 1234/1234", bus.alu_a, bus.alu_b); end
        cyc(1);
        checks++; if (bus.pc !== 32'd1) begin failures++; $display("FAIL add_pc7 got=%0d want=1", bus.pc); end
        cyc(1);
        checks++; if (bus.pc !== 32'd2) begin failures++; $display("FAIL add_pc8 got=%0d want=2", bus.pc); end
        cyc(2);
        checks++; if (bus.alu_a !== 32'h2468) begin failures++; $display("FAIL r2_value got=%h want=2468", bus.alu_a); end
    endtask

    task automatic test_flags();
        ack_delay = 0;
        load_prog(enc(6'd5, 4'd1, 4'd0, 1'b0, 16'h1234),
                  enc(6'd8, 4'd0, 4'd1, 1'b0, 16'h0001),
                  enc(6'd9, 4'd0, 4'd1, 1'b0, 16'h0001),
                  enc(6'd0, 4'd2, 4'd1, 1'b0, 16'h0001));
        do_reset();
        cyc(8);
        checks++; if ({bus.alu_f1, bus.alu_f2} !== 2'b10) begin failures++; $display("FAIL flags_eq got f1f2=%b want=10", {bus.alu_f1, bus.alu_f2}); end
        cyc(4);
        checks++; if ({bus.alu_f1, bus.alu_f2} !== 2'b01) begin failures++; $display("FAIL flags_lt got f1f2=%b want=01", {bus.alu_f1, bus.alu_f2}); end
        cyc(4);
        checks++; if ({bus.alu_f1, bus.alu_f2} !== 2'b01) begin failures++; $display("FAIL flags_op0 got f1f2=%b want=01", {bus.alu_f1, bus.alu_f2}); end
        checks++; if (bus.pc !== 32'd4) begin failures++; $display("FAIL flags_pc got=%0d want=4", bus.pc); end
    endtask

    task automatic test_branch();
        ack_delay = 0;
        load_prog(enc(6'd5, 4'd8, 4'd0, 1'b0, 16'h0040),
                  enc(6'd14, 4'd0, 4'd0, 1'b0, 16'h0000),
                  32'h0, 32'h0);
        do_reset();
        cyc(6);
        checks++; if (bus.alu_reg8 !== 32'h40 || bus.alu_strobe !== 1'b1)
            begin failures++; $display("FAIL branch_reg8 got reg8=%h strobe=%0b want 40/1", bus.alu_reg8, bus.alu_strobe); end
        cyc(2);
        checks++; if (bus.imem_addr !== 32'h40) begin failures++; $display("FAIL branch_target got=%h want=40", bus.imem_addr); end
        checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL branch_req got=%0b want=1", bus.imem_req); end
    endtask

    task automatic test_fetch_wait_illegal();
        ack_delay = 3;
        load_prog(enc(6'd5, 4'd1, 4'd0, 1'b0, 16'h0007),
                  enc(6'd20, 4'd1, 4'd1, 1'b0, 16'h0001),
                  32'h0, 32'h0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.alu_strobe !== 1'b0)
                begin failures++; $display("FAIL wait_stable%0d got req=%0b addr=%h strobe=%0b want 1/0/0", i, bus.imem_req, bus.imem_addr, bus.alu_strobe); end
        end
        cyc(3);
        checks++; if (bus.pc !== 32'd0) begin failures++; $display("FAIL wait_pc6 got=%0d want=0", bus.pc); end
        ack_delay = 0;
        cyc(1);
        checks++; if (bus.pc !== 32'd1) begin failures++; $display("FAIL wait_pc7 got=%0d want=1", bus.pc); end
        cyc(1);
        checks++; if (bus.illegal !== 1'b1 || bus.alu_strobe !== 1'b0)
            begin failures++; $display("FAIL illegal_pulse got ill=%0b strobe=%0b want 1/0", bus.illegal, bus.alu_strobe); end
        cyc(1);
        checks++; if (bus.illegal !== 1'b0 || bus.alu_strobe !== 1'b0)
            begin failures++; $display("FAIL illegal_wb got ill=%0b strobe=%0b want 0/0", bus.illegal, bus.alu_strobe); end
        cyc(1);
        checks++; if (bus.pc !== 32'd2) begin failures++; $display("FAIL illegal_pc got=%0d want=2", bus.pc); end
    endtask

    task automatic test_halt();
        ack_delay = 0;
        load_prog(enc(6'd63, 4'd0, 4'd0, 1'b0, 16'h0), 32'h0, 32'h0, 32'h0);
        do_reset();
        cyc(2);
        checks++; if (bus.halted !== 1'b1 || bus.pc !== 32'd0)
            begin failures++; $display("FAIL halt_enter got halted=%0b pc=%0d want 1/0", bus.halted, bus.pc); end
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            checks++; if (bus.imem_req !== 1'b0 || bus.alu_strobe !== 1'b0 || bus.halted !== 1'b1)
                begin failures++; $display("FAIL halt_hold%0d got req=%0b strobe=%0b halted=%0b want 0/0/1", i, bus.imem_req, bus.alu_strobe, bus.halted); end
        end
        reset = 1'b1;
        #1;
        checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL halt_reset got=%0b want=0", bus.halted); end
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        ack_delay = 0;
        load_prog(enc(6'd5, 4'd1, 4'd0, 1'b0, 16'h1234),
                  enc(6'd8, 4'd0, 4'd1, 1'b0, 16'h0001),
                  enc(6'd0, 4'd2, 4'd1, 1'b0, 16'h0001),
                  32'h0);
        do_reset();
        cyc(10);
        checks++; if (bus.alu_strobe !== 1'b1 || bus.alu_f1 !== 1'b1)
            begin failures++; $display("FAIL mid_pre got strobe=%0b f1=%0b want 1/1", bus.alu_strobe, bus.alu_f1); end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.alu_strobe !== 1'b0) begin failures++; $display("FAIL mid_strobe got=%0b want=0", bus.alu_strobe); end
        checks++; if (bus.pc !== 32'h0 || bus.imem_addr !== 32'h0)
            begin failures++; $display("FAIL mid_pc got pc=%h addr=%h want 0/0", bus.pc, bus.imem_addr); end
        checks++; if (bus.alu_f1 !== 1'b0 || bus.alu_f2 !== 1'b0)
            begin failures++; $display("FAIL mid_flags got f1=%0b f2=%0b want 0/0", bus.alu_f1, bus.alu_f2); end
        mem[0] = enc(6'd0, 4'd2, 4'd1, 1'b0, 16'h0001);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        cyc(2);
        checks++; if (bus.alu_a !== 32'h0 || bus.alu_b !== 32'h0 || bus.alu_strobe !== 1'b1)
            begin failures++; $display("FAIL mid_regs got a=%h b=%h strobe=%0b want 0/0/1", bus.alu_a, bus.alu_b, bus.alu_strobe); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        ack_delay = 0;
        reset     = 1'b1;
        test_reset();
        test_load_add();
        test_flags();
        test_branch();
        test_fetch_wait_illegal();
        test_halt();
        test_reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
